// File: rtl/pwm_cfg_ctrl_if.sv
// Byte-level link between the SPI slave and the PWM config controller.
// The SPI side presents received bytes; the controller returns the next byte to shift out.
interface pwm_cfg_ctrl_if;
    logic       ss;
    logic       rx_avail;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (output ss, output rx_avail, output rx_byte, input tx_byte);
    modport slave  (input ss, input rx_avail, input rx_byte, output tx_byte);
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// SPI command controller for a bank of PWM channels: parses header + 16-bit frames,
// owns per-channel freq/duty registers and prepares read-back bytes for the SPI slave.
module pwm_cfg_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int DEF_FREQ = 490,
    parameter int DEF_DUTY = 1250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_cfg_ctrl_if.slave        spi,
    output logic [16*NUM_CH-1:0] freq_bus,
    output logic [16*NUM_CH-1:0] duty_bus,
    output logic [NUM_CH-1:0]    cfg_upd,
    output logic                 err
);

    typedef enum logic [1:0] {S_HDR, S_LO, S_HI, S_SKIP} state_t;

    localparam logic [4:0] NCH = 5'(NUM_CH);

    state_t      state, state_nxt;
    logic        ss_p0, ss_p1, ss_p2;
    logic        rx_prev;
    logic        ss_fall, byte_evt;
    logic [3:0]  ch, ch_nxt;
    logic [4:0]  ch_inc;
    logic        sel, sel_nxt, wr, wr_nxt, ainc, ainc_nxt;
    logic [7:0]  lo_byte, lo_nxt, tx_q, tx_nxt;
    logic        err_nxt;
    logic [NUM_CH-1:0] upd_nxt;
    logic        commit;
    logic [15:0] commit_val;
    logic [7:0]  hdr_b, cur_hi_b, inc_lo_b;
    logic [15:0] freq_r [NUM_CH];
    logic [15:0] duty_r [NUM_CH];

    function automatic logic [7:0] rd_byte(input logic s, input logic [4:0] idx, input logic hi);
        logic [15:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == 5'(c)) v = s ? duty_r[c] : freq_r[c];
        end
        return hi ? v[15:8] : v[7:0];
    endfunction

    // ss_p1 is the synchronised select; ss_p2 is its previous value for edge detection
    assign ss_fall  = ss_p2 & ~ss_p1;
    assign byte_evt = spi.rx_avail & ~rx_prev & ~ss_p1;
    assign ch_inc   = {1'b0, ch} + 5'd1;

    assign hdr_b    = rd_byte(spi.rx_byte[4], {1'b0, spi.rx_byte[3:0]}, 1'b0);
    assign cur_hi_b = rd_byte(sel, {1'b0, ch}, 1'b1);
    assign inc_lo_b = rd_byte(sel, ch_inc, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        sel_nxt    = sel;
        wr_nxt     = wr;
        ainc_nxt   = ainc;
        lo_nxt     = lo_byte;
        tx_nxt     = tx_q;
        err_nxt    = ss_fall ? 1'b0 : err;
        upd_nxt    = '0;
        commit     = 1'b0;
        commit_val = {spi.rx_byte, lo_byte};
        if (ss_p1) begin
            state_nxt = S_HDR;
            tx_nxt    = 8'h00;
            lo_nxt    = 8'h00;
        end else if (byte_evt) begin
            case (state)
                S_HDR: begin
                    if (spi.rx_byte[7] || ({1'b0, spi.rx_byte[3:0]} >= NCH)) begin
                        err_nxt   = 1'b1;
                        wr_nxt    = 1'b0;
                        tx_nxt    = 8'h00;
                        state_nxt = S_SKIP;
                    end else begin
                        ch_nxt    = spi.rx_byte[3:0];
                        sel_nxt   = spi.rx_byte[4];
                        wr_nxt    = spi.rx_byte[5];
                        ainc_nxt  = spi.rx_byte[6];
                        tx_nxt    = spi.rx_byte[5] ? spi.rx_byte : hdr_b;
                        state_nxt = S_LO;
                    end
                end
                S_LO: begin
                    lo_nxt    = spi.rx_byte;
                    tx_nxt    = wr ? spi.rx_byte : cur_hi_b;
                    state_nxt = S_HI;
                end
                S_HI: begin
                    tx_nxt    = wr ? spi.rx_byte : 8'h00;
                    state_nxt = S_SKIP;
                    // a zero frequency would stall the PWM counter, so it is refused
                    if (wr && !sel && commit_val == 16'h0000) begin
                        err_nxt = 1'b1;
                    end else begin
                        if (wr) begin
                            commit = 1'b1;
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (ch == 4'(c)) upd_nxt[c] = 1'b1;
                            end
                        end
                        if (ainc) begin
                            if (ch_inc >= NCH) begin
                                err_nxt = 1'b1;
                            end else begin
                                ch_nxt    = ch_inc[3:0];
                                state_nxt = S_LO;
                                if (!wr) tx_nxt = inc_lo_b;
                            end
                        end
                    end
                end
                default: begin
                    tx_nxt = wr ? spi.rx_byte : 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            rx_prev <= 1'b0;
            ch      <= '0;
            sel     <= 1'b0;
            wr      <= 1'b0;
            ainc    <= 1'b0;
            lo_byte <= 8'h00;
            tx_q    <= 8'h00;
            err     <= 1'b0;
            cfg_upd <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                freq_r[c] <= 16'(DEF_FREQ);
                duty_r[c] <= 16'(DEF_DUTY);
            end
        end else begin
            ss_p0   <= spi.ss;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            rx_prev <= spi.rx_avail;
            ch      <= ch_nxt;
            sel     <= sel_nxt;
            wr      <= wr_nxt;
            ainc    <= ainc_nxt;
            lo_byte <= lo_nxt;
            tx_q    <= tx_nxt;
            err     <= err_nxt;
            cfg_upd <= upd_nxt;
            if (commit) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch == 4'(c)) begin
                        if (sel) duty_r[c] <= commit_val;
                        else     freq_r[c] <= commit_val;
                    end
                end
            end
        end
    end

    assign spi.tx_byte = tx_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bus
        assign freq_bus[16*c +: 16] = freq_r[c];
        assign duty_bus[16*c +: 16] = duty_r[c];
    end

endmodule
